// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store controller: the FSM state encoding,
// the RV32I load/store funct3 codes and the access-size decode.
// -----------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RMW_RD,
        ST_WR,
        ST_RESP
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD,
        SZ_ILLEGAL
    } size_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned variants exist only for loads; a store with 100/101 is illegal.
    function automatic size_e access_size(input logic we, input logic [2:0] funct3);
        case (funct3)
            F3_B:    return SZ_BYTE;
            F3_H:    return SZ_HALF;
            F3_W:    return SZ_WORD;
            F3_BU:   return we ? SZ_ILLEGAL : SZ_BYTE;
            F3_HU:   return we ? SZ_ILLEGAL : SZ_HALF;
            default: return SZ_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational lane logic for the load/store controller.
//   i_funct3      : funct3 of the current access
//   i_lane        : byte offset within the word (addr[1:0])
//   i_rword       : word read from dmem
//   i_wdata       : store data, LSB-aligned
//   o_load_data   : selected lane, sign/zero extended per funct3
//   o_merge_data  : i_rword with the store lane replaced (i_wdata for SW)
// -----------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_rword,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merge_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = 8'(i_rword >> {i_lane, 3'b000});
    assign w_half = i_lane[1] ? i_rword[31:16] : i_rword[15:0];

    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves it unassigned would infer a latch.
    always_comb begin
        o_load_data = i_rword;
        case (i_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_load_data = {24'h0, w_byte};
            F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_load_data = {16'h0, w_half};
            default: o_load_data = i_rword;
        endcase
    end

    always_comb begin
        o_merge_data = i_rword;
        case (i_funct3)
            F3_B:    o_merge_data[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
            F3_H: begin
                if (i_lane[1]) o_merge_data[31:16] = i_wdata[15:0];
                else           o_merge_data[15:0]  = i_wdata[15:0];
            end
            default: o_merge_data = i_wdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl
// Load/store controller between execute and a word-only data memory (dmem).
// Loads: one read cycle, lane extract + extension. SW: one write cycle.
// SB/SH: read-modify-write (dmem writes whole words only).
//
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req_valid/req_ready        : request handshake (ready only in IDLE)
//   req_we, req_funct3         : store flag, RV32I funct3
//   req_addr, req_wdata        : byte address, LSB-aligned store data
//   rsp_valid, rsp_rdata, rsp_err : one-cycle completion with result / error
//   mem_r_addr, mem_w_addr     : dmem word index {2'b0, addr[31:2]}
//   mem_data_in                : word written to dmem
//   mem_read, mem_write        : dmem strobes, decoded from state only
//   mem_data_out               : dmem read data (combinational)
//
// Configuration macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned halfword/word accesses return rsp_err, no access.
//   undefined : low address bits are cleared to the access size.
// -----------------------------------------------------------------------------
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_IDX_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [31:0]       mem_r_addr,
    output logic [31:0]       mem_w_addr,
    output logic [31:0]       mem_data_in,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [31:0]       mem_data_out
);

    // dmem decodes only MEM_IDX_W index bits; they must fit in the address.
    if (MEM_IDX_W < 1 || MEM_IDX_W > ADDR_W - 2) begin : g_bad_params
        $error("lsu_ctrl: MEM_IDX_W does not fit the word index of ADDR_W");
    end

    state_e            r_state;
    state_e            w_next;
    logic              r_we;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_err;
    logic [31:0]       r_rdata;
    logic [31:0]       r_merge;

    size_e             w_size;
    logic              w_err;
    logic [ADDR_W-1:0] w_addr_acc;
    logic              w_accept;
    logic [31:0]       w_load_data;
    logic [31:0]       w_merge_data;

    assign w_size   = access_size(req_we, req_funct3);
    assign w_accept = req_valid && (r_state == ST_IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_misalign;
    assign w_misalign = ((w_size == SZ_HALF) && req_addr[0]) ||
                        ((w_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    assign w_err      = (w_size == SZ_ILLEGAL) || w_misalign;
    assign w_addr_acc = req_addr;
`else
    assign w_err = (w_size == SZ_ILLEGAL);
    // Misalignment is tolerated by rounding down to the access size.
    always_comb begin
        w_addr_acc = req_addr;
        if (w_size == SZ_HALF)      w_addr_acc[0]   = 1'b0;
        else if (w_size == SZ_WORD) w_addr_acc[1:0] = 2'b00;
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (w_err)                 w_next = ST_RESP;
                    else if (!req_we)          w_next = ST_RD;
                    else if (w_size == SZ_WORD) w_next = ST_WR;
                    else                       w_next = ST_RMW_RD;
                end
            end
            ST_RD:     w_next = ST_RESP;
            ST_RMW_RD: w_next = ST_WR;
            ST_WR:     w_next = ST_RESP;
            ST_RESP:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we     <= 1'b0;
            r_funct3 <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            r_merge  <= '0;
        end else begin
            if (w_accept) begin
                r_we     <= req_we;
                r_funct3 <= req_funct3;
                r_addr   <= w_addr_acc;
                r_wdata  <= req_wdata;
                r_err    <= w_err;
                r_rdata  <= '0;   // stores and errors respond with zero
            end
            if (r_state == ST_RD)     r_rdata <= w_load_data;
            if (r_state == ST_RMW_RD) r_merge <= w_merge_data;
        end
    end

    lsu_align u_align (
        .i_funct3     (r_funct3),
        .i_lane       (r_addr[1:0]),
        .i_rword      (mem_data_out),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_merge_data (w_merge_data)
    );

    // Strobes come straight from the state register, so an asynchronous
    // reset drops mem_write at once and aborts a pending write.
    assign mem_read    = (r_state == ST_RD) || (r_state == ST_RMW_RD);
    assign mem_write   = (r_state == ST_WR);
    assign mem_r_addr  = 32'(r_addr[ADDR_W-1:2]);
    assign mem_w_addr  = 32'(r_addr[ADDR_W-1:2]);
    assign mem_data_in = (r_we && (r_funct3 == F3_W)) ? r_wdata : r_merge;

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_ctrl
// Directed bench for lsu_ctrl against a small word-organised dmem model.
// -----------------------------------------------------------------------------
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_r_addr;
    logic [31:0] mem_w_addr;
    logic [31:0] mem_data_in;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_data_out;

    int n_vec  = 0;
    int n_miss = 0;

    // dmem model: 32 words, write only when read is low.
    logic [31:0] mem [32];
    logic        pre_en = 1'b0;
    logic [4:0]  pre_idx = '0;
    logic [31:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_en)                      mem[pre_idx] <= pre_data;
        else if (mem_write && !mem_read) mem[mem_w_addr[4:0]] <= mem_data_in;
    end
    assign mem_data_out = mem[mem_r_addr[4:0]];

    always #5 clk = ~clk;

    lsu_ctrl #(.ADDR_W(32), .MEM_IDX_W(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_r_addr   (mem_r_addr),
        .mem_w_addr   (mem_w_addr),
        .mem_data_in  (mem_data_in),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_data_out (mem_data_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic preload(input logic [4:0] idx, input logic [31:0] data);
        pre_en = 1'b1; pre_idx = idx; pre_data = data;
        @(posedge clk);
        #1 pre_en = 1'b0;
        @(negedge clk);
    endtask

    // Issues one request and observes it cycle by cycle (cycle 1 = T+1).
    task automatic run_req(
        input  logic        we,
        input  logic [2:0]  f3,
        input  logic [31:0] addr,
        input  logic [31:0] wd,
        output int          rsp_cyc,
        output logic [31:0] rdata,
        output logic        err,
        output int          rd_cyc,
        output logic [31:0] rd_idx,
        output int          wr_cyc,
        output logic [31:0] wr_idx,
        output logic [31:0] wr_data,
        output logic        overlap
    );
        int n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_req", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rsp_cyc = 0; rdata = '0; err = 1'b0;
        rd_cyc = 0; rd_idx = '0; wr_cyc = 0; wr_idx = '0; wr_data = '0; overlap = 1'b0;
        for (int c = 1; c <= 8 && rsp_cyc == 0; c++) begin
            @(negedge clk);
            if (mem_read)  begin rd_cyc = c; rd_idx = mem_r_addr; end
            if (mem_write) begin wr_cyc = c; wr_idx = mem_w_addr; wr_data = mem_data_in; end
            if (mem_read && mem_write) overlap = 1'b1;
            if (rsp_valid) begin rsp_cyc = c; rdata = rsp_rdata; err = rsp_err; end
        end
        check("rsp_seen", {31'h0, rsp_cyc != 0}, 32'h1);
        check("strobe_overlap", {31'h0, overlap}, 32'h0);
    endtask

    int          rc, rdc, wrc;
    logic [31:0] rd, ri, wi, wdt;
    logic        er, ov;

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_ready",    {31'h0, req_ready}, 32'h1);
        check("rst_rsp_valid",{31'h0, rsp_valid}, 32'h0);
        check("rst_rsp_err",  {31'h0, rsp_err},   32'h0);
        check("rst_rdata",    rsp_rdata,          32'h0);
        check("rst_strobes",  {30'h0, mem_read, mem_write}, 32'h0);
        check("rst_raddr",    mem_r_addr,         32'h0);
        check("rst_waddr",    mem_w_addr,         32'h0);
        check("rst_data_in",  mem_data_in,        32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // SW then LW at 0x8.
        run_req(1'b1, 3'b010, 32'h8, 32'hDEAD_BEEF, rc, rd, er, rdc, ri, wrc, wi, wdt, ov);
        check("sw_wr_cycle",  wrc, 1);
        check("sw_wr_idx",    wi, 32'h2);
        check("sw_wr_data",   wdt, 32'hDEAD_BEEF);
        check("sw_no_read",   rdc, 0);
        check("sw_rsp_cycle", rc, 2);
        check("sw_rdata",     rd, 32'h0);
        check("sw_err",       {31'h0, er}, 32'h0);
        check("sw_mem",       mem[2], 32'hDEAD_BEEF);
        run_req(1'b0, 3'b010, 32'h8, 32'h0, rc, rd, er, rdc, ri, wrc, wi, wdt, ov);
        check("lw_rd_cycle",  rdc, 1);
        check("lw_rd_idx",    ri, 32'h2);
        check("lw_rsp_cycle", rc, 2);
        check("lw_rdata",     rd, 32'hDEAD_BEEF);
        check("lw_no_write",  wrc, 0);

        // SB 0x80 into byte 3 of 0x11223344, then LB / LBU.
        preload(5'd2, 32'h1122_3344);
        run_req(1'b1, 3'b000, 32'hB, 32'h0000_0080, rc, rd, er, rdc, ri, wrc, wi, wdt, ov);
        check("sb_rd_cycle",  rdc, 1);
        check("sb_wr_cycle",  wrc, 2);
        check("sb_rsp_cycle", rc, 3);
        check("sb_wr_data",   wdt, 32'h8022_3344);
        check("sb_mem",       mem[2], 32'h8022_3344);
        run_req(1'b0, 3'b000, 32'hB, 32'h0, rc, rd, er, rdc, ri, wrc, wi, wdt, ov);
        check("lb_rdata",     rd, 32'hFFFF_FF80);
        run_req(1'b0, 3'b100, 32'hB, 32'h0, rc, rd, er, rdc, ri, wrc, wi, wdt, ov);
        check("lbu_rdata",    rd, 32'h0000_0080);

        // SH 0xA5A5 to upper half of word 4, then LHU / LH.
        preload(5'd4, 32'h1357_9BDF);
        run_req(1'b1, 3'b001, 32'h12, 32'h1234_A5A5, rc, rd, er, rdc, ri, wrc, wi, wdt, ov);
        check("sh_wr_idx",    wi, 32'h4);
        check("sh_mem",       mem[4], 32'hA5A5_9BDF);
        run_req(1'b0, 3'b101, 32'h12, 32'h0, rc, rd, er, rdc, ri, wrc, wi, wdt, ov);
        check("lhu_rdata",    rd, 32'h0000_A5A5);
        run_req(1'b0, 3'b001, 32'h12, 32'h0, rc, rd, er, rdc, ri, wrc, wi, wdt, ov);
        check("lh_rdata",     rd, 32'hFFFF_A5A5);
        run_req(1'b0, 3'b001, 32'h10, 32'h0, rc, rd, er, rdc, ri, wrc, wi, wdt, ov);
        check("lh_low_rdata", rd, 32'hFFFF_9BDF);

        // Misaligned LW at 0x6.
        preload(5'd1, 32'hCAFE_F00D);
        run_req(1'b0, 3'b010, 32'h6, 32'h0, rc, rd, er, rdc, ri, wrc, wi, wdt, ov);
`ifdef LSU_MISALIGN_TRAP_EN
        check("mis_err",      {31'h0, er}, 32'h1);
        check("mis_rsp_cycle",rc, 1);
        check("mis_no_access",rdc + wrc, 0);
        check("mis_rdata",    rd, 32'h0);
`else
        check("mis_err",      {31'h0, er}, 32'h0);
        check("mis_rd_idx",   ri, 32'h1);
        check("mis_rsp_cycle",rc, 2);
        check("mis_rdata",    rd, 32'hCAFE_F00D);
`endif

        // Illegal funct3: load 011 and store 100.
        run_req(1'b0, 3'b011, 32'h8, 32'h0, rc, rd, er, rdc, ri, wrc, wi, wdt, ov);
        check("ill_ld_err",   {31'h0, er}, 32'h1);
        check("ill_ld_rdata", rd, 32'h0);
        check("ill_ld_cycle", rc, 1);
        check("ill_ld_access",rdc + wrc, 0);
        run_req(1'b1, 3'b100, 32'h8, 32'h5555_5555, rc, rd, er, rdc, ri, wrc, wi, wdt, ov);
        check("ill_st_err",   {31'h0, er}, 32'h1);
        check("ill_st_access",rdc + wrc, 0);
        check("ill_st_mem",   mem[2], 32'h8022_3344);

        // Reset asserted during the WR state of an SB.
        preload(5'd3, 32'h5566_7788);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'hC; req_wdata = 32'h11;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);                       // RMW_RD
        @(negedge clk);                       // WR
        check("abort_in_wr",  {31'h0, mem_write}, 32'h1);
        #1 rst_n = 1'b0;
        #1 check("abort_wr_drop", {31'h0, mem_write}, 32'h0);
        @(negedge clk);
        check("abort_mem",    mem[3], 32'h5566_7788);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_ready",  {31'h0, req_ready}, 32'h1);
        check("abort_no_rsp", {31'h0, rsp_valid}, 32'h0);
        run_req(1'b0, 3'b010, 32'hC, 32'h0, rc, rd, er, rdc, ri, wrc, wi, wdt, ov);
        check("post_abort_lw",rd, 32'h5566_7788);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller between the execute stage and the word-organised data memory (`dmem`). It accepts one RV32I load or store per transaction and converts it into word accesses. It performs byte/halfword extraction with sign or zero extension on loads. Sub-word stores use a read-modify-write sequence, because `dmem` writes whole words only and ignores cycles where read and write are both high.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width of requests.
- `MEM_IDX_W`, 5, number of word-index bits `dmem` decodes. Address bits above this are passed through but not decoded.

Ports:
- `clk` in 1, single clock, rising edge.
- `rst_n` in 1, asynchronous active-low reset.
- `req_valid` in 1, request present.
- `req_ready` out 1, controller idle and able to accept a request.
- `req_we` in 1, 1 = store, 0 = load.
- `req_funct3` in 3, RV32I funct3 of the load/store.
- `req_addr` in ADDR_W, byte address.
- `req_wdata` in 32, store data, LSB-aligned.
- `rsp_valid` out 1, one-cycle completion pulse.
- `rsp_rdata` out 32, extended load result; 0 for stores and errors.
- `rsp_err` out 1, qualified by `rsp_valid`; illegal funct3 or trapped misalignment.
- `mem_r_addr` out 32, `dmem` read word index = `{2'b0, addr_q[31:2]}`.
- `mem_w_addr` out 32, `dmem` write word index, same encoding as `mem_r_addr`.
- `mem_data_in` out 32, word written to `dmem`.
- `mem_read` out 1, `dmem` read enable.
- `mem_write` out 1, `dmem` write enable.
- `mem_data_out` in 32, `dmem` read data, combinational from `mem_r_addr`.

## Operation
- Request handshake: a request is accepted on a rising edge where `req_valid && req_ready`. At acceptance the controller latches `we`, `funct3`, `addr`, `wdata`, and the error flag.
- `req_ready` is high only in IDLE.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value is illegal.
- Misalignment: a halfword access with `addr[0]=1`, or a word access with `addr[1:0]!=0`.
- FSM states: IDLE, RD, RMW_RD, WR, RESP.
  - IDLE: on accept, go to RESP if there is an error, RD for a load, WR for SW, RMW_RD for SB/SH.
  - RD: `mem_read=1`. Capture the byte lane selected by `addr_q[1:0]` (the halfword lane by `addr_q[1]`), extended per funct3, into `rdata_q`. Go to RESP.
  - RMW_RD: `mem_read=1`. Capture `mem_data_out`, merge `wdata_q[7:0]` or `[15:0]` into the addressed lane, store the result in `merge_q`. Go to WR.
  - WR: `mem_write=1`. `mem_data_in` is `merge_q` for sub-word stores and `wdata_q` for SW. Go to RESP.
  - RESP: `rsp_valid=1` for exactly one cycle. Go to IDLE.
- Memory strobes are decoded from state only.
- `mem_read` and `mem_write` are never high in the same cycle.
- `mem_r_addr` and `mem_w_addr` are driven with the word index in every state.
- Reset values: state IDLE; `req_ready=1`; `rsp_valid=0`; `rsp_err=0`; `rsp_rdata=0`; `mem_read=0`; `mem_write=0`; `mem_data_in=0`; `mem_r_addr=0`; `mem_w_addr=0`; all internal registers 0.
- Reset mid-operation: deasserting into reset returns to IDLE immediately. A pending WR is aborted with no `dmem` write, because `mem_write` drops asynchronously. No response is produced.

## Timing
- Request accepted at edge T.
- Load: RD in cycle T+1; `rsp_valid` in T+2.
- SW: WR in T+1; `rsp_valid` in T+2.
- SB/SH: RMW_RD in T+1, WR in T+2, `rsp_valid` in T+3.
- Error: `rsp_valid` and `rsp_err` in T+1; no memory strobe.
- Next request may be accepted at the first edge after RESP (back-to-back throughput: load/SW 1 per 3 cycles, SB/SH 1 per 4 cycles).
- `rsp_valid` has no backpressure; the consumer must take it.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: a misaligned access gives an error response and makes no memory access.
- Not defined: misalignment is not an error. Low address bits are cleared to the access size (halfword `addr[0]=0`, word `addr[1:0]=0`) and the access proceeds. `rsp_err` is raised only for illegal funct3.

## Structure
- Shared package `lsu_pkg` holds:
  - the state enum;
  - funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - the access-size decode function.
- Sub-module `lsu_align` is purely combinational: load lane extract plus extension, and store lane merge. It is instantiated once.
- The FSM and registers stay in `lsu_ctrl`.

## Test plan
- SW addr 0x0000_0008, data 0xDEAD_BEEF, then LW same address:
  - `mem_write` in T+1 with index 2;
  - load `rsp_rdata=0xDEADBEEF` in T+2.
- SB 0x80 to 0x0000_000B over word 0x1122_3344, then LB and LBU 0x0B:
  - word becomes 0x8022_3344;
  - LB returns 0xFFFF_FF80;
  - LBU returns 0x0000_0080.
- SH 0xA5A5 to 0x0000_0012, then LHU and LH 0x12:
  - LHU returns 0x0000_A5A5;
  - LH returns 0xFFFF_A5A5.
- LW 0x0000_0006:
  - with macro: `rsp_err=1` in T+1, no strobes;
  - without macro: reads word index 1.
- funct3=011 load: `rsp_err=1`, `rsp_rdata=0`, no memory access.
- Assert `rst_n=0` during the WR state of an SB: `mem_write` falls immediately, memory is unchanged, and `req_ready=1` after release.
